// File: rtl/switch_pkg.sv
// Shared types and constants for the push-button BCD counter path.
// Holds the increment FSM encoding, BCD limits and default timing.
package switch_pkg;

    // Increment FSM states.
    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } inc_state_e;

    // Two-digit BCD value, tens in the upper nibble.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Default timing for a 25 MHz clock.
    localparam int unsigned DEF_DEBOUNCE_LIMIT = 250000;
    localparam int unsigned DEF_HOLD_LIMIT     = 12500000;
    localparam int unsigned DEF_REPEAT_LIMIT   = 2500000;

    // True when the value is the top of the range (99).
    function automatic logic bcd_is_max(input bcd_t v);
        return (v.tens >= BCD_MAX_DIGIT) &&
               (v.ones >= BCD_MAX_DIGIT);
    endfunction

    // Next BCD value, 99 rolls over to 00.
    // Any digit at or above 9 is treated as 9 so the
    // result never leaves 0-9.
    function automatic bcd_t bcd_inc(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.ones < BCD_MAX_DIGIT) begin
            r.ones = v.ones + 4'd1;
        end else begin
            r.ones = 4'd0;
            if (v.tens < BCD_MAX_DIGIT) begin
                r.tens = v.tens + 4'd1;
            end else begin
                r.tens = 4'd0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a stable-count debounce filter.
// Ports: i_Clk, i_Rst (sync, active-high), i_Switch raw, o_Switch filtered.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int unsigned CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter tracks how long the synchronized input has
    // disagreed with the filtered value; the toggle happens on
    // the cycle the count would reach the limit.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_q <= 2'b00;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], i_Switch};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_Switch = filt_q;

endmodule

// File: rtl/switch_bcd_counter.sv
// Debounced increment/clear buttons driving a two-digit BCD count
// with press-and-hold auto-repeat.
// Ports: i_Clk, i_Rst (sync, active-high), i_Switch_Inc/i_Switch_Clr
// raw buttons; o_Tens/o_Ones BCD digits; o_Inc_Pulse, o_Wrap strobes.
module switch_bcd_counter
    import switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int unsigned HOLD_LIMIT     = DEF_HOLD_LIMIT,
    parameter int unsigned REPEAT_LIMIT   = DEF_REPEAT_LIMIT
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_Inc,
    input  logic       i_Switch_Clr,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic       o_Inc_Pulse,
    output logic       o_Wrap
);

    localparam int unsigned TMAX =
        (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
    localparam int unsigned TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_LIMIT - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_LIMIT - 1);

    logic inc_f;
    logic clr_f;
    logic inc_prev_q;
    logic clr_prev_q;
    logic inc_rise;
    logic clr_rise;
    logic inc_evt;

    inc_state_e    state_q;
    logic [TW-1:0] timer_q;

    bcd_t count_q;
    bcd_t count_d;
    logic pulse_q;
    logic pulse_d;
    logic wrap_q;
    logic wrap_d;

    switch_debounce #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_deb_inc (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Switch(i_Switch_Inc),
        .o_Switch(inc_f)
    );

    switch_debounce #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_deb_clr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Switch(i_Switch_Clr),
        .o_Switch(clr_f)
    );

    assign inc_rise = inc_f & ~inc_prev_q;
    assign clr_rise = clr_f & ~clr_prev_q;

    // Increment request for this cycle, decoded from the FSM
    // state so the count register sees it with one cycle latency.
    always_comb begin
        inc_evt = 1'b0;
        unique case (state_q)
            RELEASED:  inc_evt = inc_rise;
            HELD:      inc_evt = inc_f && (timer_q == HOLD_LAST);
            REPEATING: inc_evt = inc_f && (timer_q == REPEAT_LAST);
            default:   inc_evt = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            inc_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            inc_prev_q <= inc_f;
            clr_prev_q <= clr_f;
        end
    end

    // Hold/repeat FSM. A clear restarts the hold phase if the
    // increment button is still down, so the next step comes a
    // full hold time after the clear.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= RELEASED;
            timer_q <= '0;
        end else if (clr_rise) begin
            state_q <= inc_f ? HELD : RELEASED;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                RELEASED: begin
                    timer_q <= '0;
                    if (inc_rise) begin
                        state_q <= HELD;
                    end
                end
                HELD: begin
                    if (!inc_f) begin
                        state_q <= RELEASED;
                        timer_q <= '0;
                    end else if (timer_q == HOLD_LAST) begin
                        state_q <= REPEATING;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                REPEATING: begin
                    if (!inc_f) begin
                        state_q <= RELEASED;
                        timer_q <= '0;
                    end else if (timer_q == REPEAT_LAST) begin
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    timer_q <= '0;
                end
            endcase
        end
    end

    // Clear outranks a coincident increment and silences both strobes.
    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        wrap_d  = 1'b0;
        if (clr_rise) begin
            count_d = '0;
        end else if (inc_evt) begin
            count_d = bcd_inc(count_q);
            pulse_d = 1'b1;
            wrap_d  = bcd_is_max(count_q);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count_q <= '0;
            pulse_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_Tens      = count_q.tens;
    assign o_Ones      = count_q.ones;
    assign o_Inc_Pulse = pulse_q;
    assign o_Wrap      = wrap_q;

endmodule

// File: tb/tb_switch_bcd_counter.sv
// Directed and randomized bench for switch_bcd_counter,
// checked every cycle against a count/schedule reference model.
module tb_switch_bcd_counter;

    localparam int L = 4;
    localparam int H = 20;
    localparam int R = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc;
    logic       clr;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       pulse;
    logic       wrap;

    always #5 clk = ~clk;

    switch_bcd_counter #(
        .DEBOUNCE_LIMIT(L),
        .HOLD_LIMIT    (H),
        .REPEAT_LIMIT  (R)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Switch_Inc(inc),
        .i_Switch_Clr(clr),
        .o_Tens      (tens),
        .o_Ones      (ones),
        .o_Inc_Pulse (pulse),
        .o_Wrap      (wrap)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: count as an integer 0..99, increments
    // scheduled arithmetically from an anchor cycle.
    longint cyc = 0;
    int     m_count = 0;
    bit     m_pulse = 0;
    bit     m_wrap  = 0;
    bit     m_raw1[2];
    bit     m_raw2[2];
    bit     m_filt[2];
    bit     m_prev[2];
    int     m_run[2];
    longint anchor = 0;
    bit     anchor_ok = 0;

    // Observed strobe statistics.
    int     n_pulse = 0;
    int     n_wrap  = 0;
    int     n_wrap_ok = 0;
    longint pulse_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ri, input bit rc);
        bit     rise_i;
        bit     rise_c;
        bit     evt;
        longint d;
        if (r) begin
            m_count = 0;
            m_pulse = 0;
            m_wrap  = 0;
            anchor_ok = 0;
            for (int k = 0; k < 2; k++) begin
                m_raw1[k] = 0;
                m_raw2[k] = 0;
                m_filt[k] = 0;
                m_prev[k] = 0;
                m_run[k]  = 0;
            end
        end else begin
            rise_i = m_filt[0] && !m_prev[0];
            rise_c = m_filt[1] && !m_prev[1];
            evt = 0;
            if (!m_filt[0]) begin
                anchor_ok = 0;
            end else if (rise_i) begin
                anchor = cyc;
                anchor_ok = 1;
                evt = 1;
            end else if (anchor_ok) begin
                d = cyc - anchor;
                evt = (d >= H) && ((d - H) % R == 0);
            end
            if (rise_c) begin
                m_count = 0;
                m_pulse = 0;
                m_wrap  = 0;
                if (m_filt[0]) begin
                    anchor = cyc;
                    anchor_ok = 1;
                end
            end else if (evt) begin
                m_wrap  = (m_count == 99);
                m_count = (m_count + 1) % 100;
                m_pulse = 1;
            end else begin
                m_pulse = 0;
                m_wrap  = 0;
            end
            for (int k = 0; k < 2; k++) begin
                m_prev[k] = m_filt[k];
                if (m_raw2[k] != m_filt[k]) begin
                    m_run[k]++;
                    if (m_run[k] == L) begin
                        m_filt[k] = !m_filt[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_raw2[k] = m_raw1[k];
            end
            m_raw1[0] = ri;
            m_raw1[1] = rc;
        end
        cyc++;
    endtask

    task automatic tick();
        logic [9:0] exp;
        @(posedge clk);
        model_step(rst, inc, clr);
        #1;
        exp = {4'(m_count / 10), 4'(m_count % 10), m_pulse, m_wrap};
        chk("cycle", {22'b0, tens, ones, pulse, wrap}, {22'b0, exp});
        if (pulse === 1'b1) begin
            n_pulse++;
            pulse_cyc.push_back(cyc);
        end
        if (wrap === 1'b1) begin
            n_wrap++;
            if (pulse === 1'b1 && tens === 4'd0 && ones === 4'd0)
                n_wrap_ok++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_pulse = 0;
        n_wrap = 0;
        n_wrap_ok = 0;
        pulse_cyc.delete();
    endtask

    task automatic press();
        inc = 1'b1;
        ticks(8);
        inc = 1'b0;
        ticks(8);
    endtask

    initial begin
        int guard;
        int len;
        int mode;
        rst = 1'b1;
        inc = 1'b0;
        clr = 1'b0;
        ticks(2);
        chk("reset_state", {28'b0, tens, ones, pulse, wrap}, 32'd0);
        rst = 1'b0;

        // Single press: digits change 7 edges after the raw rise.
        inc = 1'b1;
        ticks(6);
        chk("t1_before", {24'b0, tens, ones}, 32'h00);
        tick();
        chk("t1_at", {23'b0, tens, ones, pulse}, {23'b0, 8'h01, 1'b1});
        ticks(3);
        inc = 1'b0;
        ticks(10);
        chk("t1_after", {24'b0, tens, ones}, 32'h01);
        chk("t1_pulses", n_pulse, 1);

        // Glitch rejection.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            inc = 1'b1;
            ticks(3);
            inc = 1'b0;
            ticks(5);
        end
        chk("t2_count", {24'b0, tens, ones}, 32'h00);
        chk("t2_pulses", n_pulse, 0);

        // Auto-repeat: 48 filtered-high cycles give 7 steps.
        do_reset();
        inc = 1'b1;
        ticks(48);
        inc = 1'b0;
        ticks(15);
        chk("t3_count", {24'b0, tens, ones}, 32'h07);
        chk("t3_pulses", n_pulse, 7);
        if (pulse_cyc.size() == 7) begin
            chk("t3_hold_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), H);
            for (int k = 2; k < 7; k++)
                chk("t3_rep_gap", 32'(pulse_cyc[k] - pulse_cyc[k-1]), R);
        end

        // Wrap.
        do_reset();
        for (int p = 0; p < 98; p++) press();
        chk("t4_98", {24'b0, tens, ones}, 32'h98);
        press();
        chk("t4_99", {24'b0, tens, ones}, 32'h99);
        chk("t4_no_wrap_yet", n_wrap, 0);
        press();
        chk("t4_00", {24'b0, tens, ones}, 32'h00);
        chk("t4_wrap_once", n_wrap, 1);
        chk("t4_wrap_with_pulse", n_wrap_ok, 1);

        // Clear priority over a coincident increment.
        do_reset();
        for (int p = 0; p < 37; p++) press();
        chk("t5_37", {24'b0, tens, ones}, 32'h37);
        clr = 1'b1;
        inc = 1'b1;
        ticks(6);
        chk("t5_pre", {24'b0, tens, ones}, 32'h37);
        tick();
        chk("t5_clear", {23'b0, tens, ones, pulse}, 32'h000);
        ticks(H - 1);
        chk("t5_hold", {24'b0, tens, ones}, 32'h00);
        tick();
        chk("t5_step", {23'b0, tens, ones, pulse}, {23'b0, 8'h01, 1'b1});
        clr = 1'b0;
        inc = 1'b0;
        ticks(10);

        // Reset while auto-repeating.
        do_reset();
        inc = 1'b1;
        guard = 0;
        while (m_count != 12 && guard < 200) begin
            tick();
            guard++;
        end
        chk("t6_reach12", {24'b0, tens, ones}, 32'h12);
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_reset", {22'b0, tens, ones, pulse, wrap}, 32'd0);
        ticks(L + 2);
        chk("t6_wait", {24'b0, tens, ones}, 32'h00);
        tick();
        chk("t6_press", {23'b0, tens, ones, pulse}, {23'b0, 8'h01, 1'b1});
        inc = 1'b0;
        ticks(10);

        // Randomized bursts: bounce, holds, clears, occasional reset.
        do_reset();
        for (int b = 0; b < 80; b++) begin
            mode = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 12));
            if (mode <= 2) begin
                for (int i = 0; i < len; i++) begin
                    inc = 1'($urandom);
                    tick();
                end
            end else if (mode <= 5) begin
                inc = 1'b1;
                ticks(int'($urandom_range(5, 60)));
            end else if (mode <= 7) begin
                clr = 1'b1;
                if ($urandom_range(0, 1) == 1) inc = 1'b1;
                ticks(len);
                clr = 1'b0;
            end else if (mode == 8) begin
                inc = 1'b0;
                ticks(len);
            end else begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        inc = 1'b0;
        clr = 1'b0;
        ticks(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_bcd_counter.md
Name: switch_bcd_counter

Overview:
Upstream stage for the two-digit seven-segment display path. It conditions two raw push-buttons (increment, clear) and maintains a two-digit BCD count, 00-99. It adds press-and-hold auto-repeat, and emits tens and ones nibbles that feed two binary-to-seven-segment decoders directly. It replaces the ad-hoc edge-detect-and-count logic in top-level display projects.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive cycles a synchronized input must differ from the filtered value before the filtered value flips (10 ms at 25 MHz); must be >= 1.
HOLD_LIMIT, 12500000, cycles the debounced increment switch must stay high after its rise before auto-repeat starts (0.5 s); must be >= 1.
REPEAT_LIMIT, 2500000, cycles between auto-repeat increments (0.1 s); must be >= 1.

Ports:
i_Clk  input  1  system clock; all logic on rising edge
i_Rst  input  1  synchronous, active-high reset
i_Switch_Inc  input  1  raw increment button, active-high, asynchronous to i_Clk
i_Switch_Clr  input  1  raw clear button, active-high, asynchronous to i_Clk
o_Tens  output  4  BCD tens digit, 0-9
o_Ones  output  4  BCD ones digit, 0-9
o_Inc_Pulse  output  1  one-cycle strobe on every cycle the count is incremented
o_Wrap  output  1  one-cycle strobe when the count rolls from 99 to 00

Behaviour:
- Reset: i_Rst high at a rising edge forces all of the following to 0:
  - o_Tens, o_Ones, o_Inc_Pulse, o_Wrap
  - synchronizer flops, filtered switch values, edge-detect history, all timers
  - the FSM, which goes to RELEASED
- Reset has priority over every other event and may arrive mid-debounce or mid-repeat.
- Synchronizer: each raw input passes through 2 flops before filtering (2-cycle latency).
- Debounce, per switch, on the synchronized value:
  - Counter of width $clog2(DEBOUNCE_LIMIT+1).
  - Synchronized value equals filtered value: counter cleared.
  - Otherwise the counter increments; when it reaches DEBOUNCE_LIMIT, the filtered value toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_LIMIT cycles are fully rejected.
- A button held through reset release counts as a press once it has been debounced.
- Clear: on the rising edge of filtered clr, the count becomes 00 on the next cycle.
  - The increment FSM goes to RELEASED if filtered inc is low, otherwise stays or goes to HELD with its hold timer restarted.
  - Clear generates no o_Inc_Pulse.
- Increment FSM (states RELEASED, HELD, REPEATING):
  - RELEASED: rising edge of filtered inc -> increment, go to HELD, clear the timer.
  - HELD: timer counts each cycle. Timer reaches HOLD_LIMIT-1 while filtered inc is high -> increment, go to REPEATING, clear the timer. Filtered inc low -> RELEASED, no increment.
  - REPEATING: timer reaches REPEAT_LIMIT-1 -> increment, clear the timer. Filtered inc low -> RELEASED.
  - Resulting increment times, relative to the filtered rise at t0: t0, t0+HOLD_LIMIT, then every REPEAT_LIMIT cycles.
  - Timer width: $clog2(max(HOLD_LIMIT, REPEAT_LIMIT)).
- Simultaneous clear and increment in the same cycle: clear wins. The count becomes 00, and o_Inc_Pulse and o_Wrap stay 0.
- Increment arithmetic, with the result registered (1-cycle latency from the event; o_Inc_Pulse is asserted in the same cycle the new digits appear):
  - Ones < 9: ones+1.
  - Ones = 9 and tens < 9: ones=0, tens+1.
  - 99: becomes 00 and o_Wrap=1 for that one cycle.
- End-to-end latency, from a raw inc edge held stable to the updated digits: DEBOUNCE_LIMIT+3 cycles.
- Digits never leave 0-9.
- Outputs are active-high BCD; segment inversion belongs to the downstream decoder/top level.

Decomposition:
- Shared package switch_pkg holds:
  - FSM state encoding (RELEASED=2'd0, HELD=2'd1, REPEATING=2'd2)
  - BCD_MAX_DIGIT=4'd9
  - default timing constants for a 25 MHz clock
- One sub-module: switch_debounce (2-flop synchronizer plus stable-count filter, parameter DEBOUNCE_LIMIT, ports i_Clk, i_Rst, i_Switch, o_Switch), instantiated twice.
- Edge detection, FSM and the BCD counter stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_LIMIT=4, HOLD_LIMIT=20, REPEAT_LIMIT=5.
1. Single press: raw inc high for 10 cycles, then low for 10. -> Count 00 to 01 exactly DEBOUNCE_LIMIT+3=7 cycles after the raw rise; one o_Inc_Pulse; no further change.
2. Glitch rejection: raw inc high for 3 cycles, low, repeated 5 times. -> Count stays 00; o_Inc_Pulse never asserted.
3. Auto-repeat: filtered inc held high for 48 cycles. -> Increments at t0, t0+20, +25, +30, +35, +40, +45; final count 07; no increment after release.
4. Wrap: preload to 98 via 98 single presses, then 2 more presses. -> 99 then 00; o_Wrap high exactly one cycle, coincident with the 00 update and the last o_Inc_Pulse.
5. Clear priority: count 37, raw clr and raw inc rise on the same cycle. -> Count becomes 00 when the filtered edges coincide; o_Inc_Pulse=0 that cycle; inc still held goes to HELD, next increment HOLD_LIMIT later gives 01.
6. Reset mid-repeat: count 12 in REPEATING, assert i_Rst for one cycle while inc stays held. -> Next cycle digits 00, strobes 0, FSM RELEASED; after release, one press is registered after DEBOUNCE_LIMIT+3 cycles (count 01).
